// File: rtl/hub75_capture.sv
// hub75_capture
// Receive-side model of a HUB75 LED-matrix link. Deserialises the pixel
// stream, commits each latched row pair into a 64x32 RGB frame image and
// reports row/frame events plus sticky protocol errors.
//
// Ports
//   clk_i          system clock, one pixel sampled per cycle
//   rst_i          asynchronous active-high reset
//   a_i..d_i       row address {d,c,b,a}
//   r0_i,g0_i,b0_i upper-half pixel colour
//   r1_i,g1_i,b1_i lower-half pixel colour
//   oe_i           high = shifting window (panel blanked)
//   lat_i          latch strobe
//   clr_err_i      synchronous clear of sticky error flags
//   frame_map_o    captured image; pixel (r,c) R/G/B at
//                  MAP_W-1/2/3-(r*COLS+c)*3
//   row_valid_o    one-cycle pulse on each row-pair commit
//   row_idx_o      row address of the last commit
//   frame_done_o   pulse with the commit of row ROWS_HALF-1
//   short_err_o    sticky: latch with fewer than COLS samples
//   seq_err_o      sticky: committed row not previous+1
//
// state | meaning
// IDLE  | waiting for a shift window or a latch
// SHIFT | sampling pixels into the shift register
// LATCH | LAT rise seen: commit (or flag short row) this cycle
// HOLD  | LAT still high after the commit; wait for it to fall
module hub75_capture #(
   parameter int COLS      = 64,
   parameter int ROWS_HALF = 16,
   parameter int MAP_W     = 2 * ROWS_HALF * COLS * 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             a_i,
   input  logic             b_i,
   input  logic             c_i,
   input  logic             d_i,
   input  logic             r0_i,
   input  logic             g0_i,
   input  logic             b0_i,
   input  logic             r1_i,
   input  logic             g1_i,
   input  logic             b1_i,
   input  logic             oe_i,
   input  logic             lat_i,
   input  logic             clr_err_i,
   output logic [MAP_W-1:0] frame_map_o,
   output logic             row_valid_o,
   output logic [3:0]       row_idx_o,
   output logic             frame_done_o,
   output logic             short_err_o,
   output logic             seq_err_o
);

   localparam int CNT_W = $clog2(COLS + 2);
   localparam int ROW_W = COLS * 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic                     lat_q;
   logic [COLS-1:0][5:0]     sr_q, sr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
   logic [3:0]               addr_q, addr_d;
   logic                     first_q, first_d;
   logic [MAP_W-1:0]         frame_q, frame_d;
   logic                     row_valid_q, row_valid_d;
   logic [3:0]               row_idx_q, row_idx_d;
   logic                     frame_done_q, frame_done_d;
   logic                     short_q, short_d;
   logic                     seq_q, seq_d;

   logic                     sample_en;
   logic                     lat_rise;
   logic                     commit;
   logic [5:0]               pix;
   logic [3:0]               addr_in;
   logic [3:0]               row_nxt;
   logic [ROW_W-1:0]         up_row;
   logic [ROW_W-1:0]         lo_row;

   assign sample_en = oe_i & ~lat_i;
   assign lat_rise  = lat_i & ~lat_q;
   assign pix       = {r0_i, g0_i, b0_i, r1_i, g1_i, b1_i};
   assign addr_in   = {d_i, c_i, b_i, a_i};
   assign row_nxt   = (row_idx_q == 4'(ROWS_HALF - 1)) ? 4'd0 : row_idx_q + 4'd1;

   // Index 0 holds the newest sample, so the register always carries the
   // last COLS samples and any leading extras fall off the old end.
   assign sr_d    = sample_en ? {sr_q[COLS-2:0], pix} : sr_q;
   assign cnt_inc = (sample_en && (cnt_q != CNT_W'(COLS + 1))) ? cnt_q + 1'b1 : cnt_q;

   // Oldest sample lands in column 0, which sits at the MSB end of a row.
   always_comb begin
      up_row = '0;
      lo_row = '0;
      for (int c = 0; c < COLS; c++) begin
         up_row[ROW_W-1-3*c -: 3] = sr_q[COLS-1-c][5:3];
         lo_row[ROW_W-1-3*c -: 3] = sr_q[COLS-1-c][2:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_inc;
      addr_d       = addr_q;
      first_d      = first_q;
      frame_d      = frame_q;
      row_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      row_idx_d    = row_idx_q;
      short_d      = short_q;
      seq_d        = seq_q;
      commit       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (lat_rise) begin
               state_d = LATCH;
               addr_d  = addr_in;
            end else if (sample_en) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (lat_rise) begin
               state_d = LATCH;
               addr_d  = addr_in;
            end else if (!oe_i && !lat_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         LATCH: begin
            if (cnt_q >= CNT_W'(COLS)) begin
               commit = 1'b1;
            end else begin
               short_d = 1'b1;
            end
            // A sample taken on the exit edge already belongs to the next row.
            cnt_d = sample_en ? CNT_W'(1) : '0;
            if (lat_i) begin
               state_d = HOLD;
            end else if (oe_i) begin
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (!lat_i) begin
               state_d = oe_i ? SHIFT : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (commit) begin
         row_valid_d  = 1'b1;
         row_idx_d    = addr_q;
         frame_done_d = (addr_q == 4'(ROWS_HALF - 1));
         first_d      = 1'b0;
         if (!first_q && (addr_q != row_nxt)) begin
            seq_d = 1'b1;
         end
         for (int r = 0; r < ROWS_HALF; r++) begin
            if (addr_q == 4'(r)) begin
               frame_d[MAP_W-1-r*ROW_W -: ROW_W]               = up_row;
               frame_d[MAP_W-1-(r+ROWS_HALF)*ROW_W -: ROW_W]   = lo_row;
            end
         end
      end

      if (clr_err_i) begin
         short_d = 1'b0;
         seq_d   = 1'b0;
         first_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         lat_q        <= 1'b0;
         sr_q         <= '0;
         cnt_q        <= '0;
         addr_q       <= '0;
         first_q      <= 1'b1;
         frame_q      <= '0;
         row_valid_q  <= 1'b0;
         row_idx_q    <= '0;
         frame_done_q <= 1'b0;
         short_q      <= 1'b0;
         seq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_q        <= lat_i;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         first_q      <= first_d;
         frame_q      <= frame_d;
         row_valid_q  <= row_valid_d;
         row_idx_q    <= row_idx_d;
         frame_done_q <= frame_done_d;
         short_q      <= short_d;
         seq_q        <= seq_d;
      end
   end

   assign frame_map_o  = frame_q;
   assign row_valid_o  = row_valid_q;
   assign row_idx_o    = row_idx_q;
   assign frame_done_o = frame_done_q;
   assign short_err_o  = short_q;
   assign seq_err_o    = seq_q;

endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Receive-side model of the HUB75 LED-matrix link. It sits on the panel end of the driver's A–D, R0/G0/B0/R1/G1/B1, OE and LAT outputs.
- It deserialises the pixel stream and commits each latched row pair into a frame image. The image uses the same 6144-bit, 64x32 RGB packing as the menu bitmap.
- It also reports row/frame events and protocol errors. Used for loop-back checking of the matrix driver, both on-chip and in simulation.

Parameters:
- COLS, 64, pixels shifted per row; the shift depth.
- ROWS_HALF, 16, row-address range; panel height is 2*ROWS_HALF.
- MAP_W, 6144, frame_map width; equals 2*ROWS_HALF*COLS*3.

Ports:
- clk  in  1  system clock; one pixel sampled per cycle.
- rst  in  1  asynchronous, active-high reset.
- A  in  1  row address bit 0.
- B  in  1  row address bit 1.
- C  in  1  row address bit 2.
- D  in  1  row address bit 3.
- R0, G0, B0  in  1 each  upper-half pixel colour.
- R1, G1, B1  in  1 each  lower-half pixel colour.
- OE  in  1  high = shifting window (panel blanked).
- LAT  in  1  latch strobe.
- clr_err  in  1  synchronous clear of the sticky error flags.
- frame_map  out  MAP_W  captured image. Pixel (r,c) occupies bits MAP_W-1-(r*COLS+c)*3 (R), MAP_W-2-... (G), MAP_W-3-... (B).
- row_valid  out  1  one-cycle pulse: a row pair was committed.
- row_idx  out  4  {D,C,B,A} of the last committed row; holds between commits.
- frame_done  out  1  one-cycle pulse, coincident with row_valid when row_idx==ROWS_HALF-1.
- short_err  out  1  sticky: a latch arrived with fewer than COLS samples.
- seq_err  out  1  sticky: a committed row was not previous+1 mod ROWS_HALF.

Behaviour:
- Reset values: frame_map=0, row_valid=0, row_idx=0, frame_done=0, short_err=0, seq_err=0; sample count 0; state IDLE; first-row flag set.
- Sampling: every clk edge with OE=1 and LAT=0 shifts {R0,G0,B0,R1,G1,B1} into a COLS-deep shift register. The sample counter increments and saturates at COLS+1.
- The register always holds the most recent COLS samples. Leading extra samples are discarded; this tolerates the driver's delay cycle and its one-cycle data lag.
- State IDLE:
  - OE=1 & LAT=0 -> SHIFT.
  - LAT rising -> LATCH; this is a latch with count 0 and sets short_err.
- State SHIFT: keep sampling.
  - LAT rising (LAT=1 while the registered LAT was 0) -> LATCH.
  - OE=0 with LAT=0 -> abort to IDLE; count cleared; no flags.
- State LATCH (one commit per LAT rising edge):
  - If count >= COLS: write the oldest sample to column 0 and the newest to column COLS-1.
  - Upper-half bits go to row {D,C,B,A}; lower-half bits go to row {D,C,B,A}+ROWS_HALF. Both rows are written in parallel on the same edge.
  - On a commit: row_valid=1 and row_idx updated on the same edge frame_map changes, i.e. 1 cycle after LAT is first sampled high.
  - If count < COLS: no write, no row_valid, short_err set.
  - Count cleared in both cases.
  - LAT held high for several cycles still produces one commit only; samples are ignored while LAT=1.
  - Exit when LAT falls: OE=1 -> SHIFT, else IDLE.
- Row sequence check:
  - The first commit after reset or clr_err is not checked.
  - After that, a commit with {D,C,B,A} != (row_idx+1) mod ROWS_HALF sets seq_err. The row is still committed.
- Wrap-around: after row 15 (row_idx==ROWS_HALF-1), the expected next row is 0; frame_done pulses on the commit of row 15.
- clr_err wins over a same-cycle error set: flags read 0 next cycle. The first-row flag is set.
- Reset asserted mid-row: everything returns to reset values immediately and the partial row is lost.
- Address bits are sampled in the LAT-rise cycle only; A–D changes during SHIFT are ignored.

Test Plan:
- Shift 64 samples with R0=1,G0=0,B0=0 and R1=0,G1=0,B1=1 at {D,C,B,A}=5, then LAT=1.
  - frame_map row 5 all red, row 21 all blue.
  - row_valid=1 exactly 1 cycle after LAT sampled high; row_idx=5.
- Shift 66 samples with pattern index i (R0=i[0]) at row 0, then latch.
  - Samples 2..65 land in columns 0..63; samples 0..1 are dropped; no errors.
- Shift 40 samples, then latch at row 3 -> short_err=1, no row_valid, frame_map unchanged.
  - Then pulse clr_err -> short_err=0.
- Latch rows 0..15 in order, 64 samples each -> 16 row_valid pulses, one frame_done on row 15, seq_err=0.
  - Next latch at row 0 -> still no seq_err.
- Latch row 4 followed by row 6 -> seq_err=1 and row 6 still committed. Hold LAT high 5 cycles -> single row_valid.
- Connect the matrix driver in START state with a known menuMap.
  - After 16 driver rows, frame_map matches the expected image aligned to the driver's output lag.
  - Assert rst mid-GET -> all outputs 0 on the next edge.
